// File: rtl/asin_lookup.sv
// ---------------------------------------------------------------------------
// asin_lookup
//
// Recovers a rotation angle from a Q12 sine magnitude (4096 = 1.0) and a
// sign flag. A 19-entry quarter-wave sine table (0..90 deg in 5 deg steps)
// is searched with a fixed-length binary search. The final entry is then
// either rounded to the nearest table angle or kept as the floor entry.
// The result is reported in the 0..359 degree angle-bus convention.
//
// Ports:
//   clk       in   1   system clock, all logic on the rising edge
//   rst_n     in   1   synchronous reset, active-low
//   start     in   1   request pulse, only sampled while idle
//   value     in  13   unsigned Q12 sine magnitude, saturated at 4096
//   negative  in   1   sign of the sine value
//   busy      out  1   high from the cycle after acceptance until done
//   done      out  1   single-cycle pulse when angle/index are valid
//   angle     out  9   result in degrees, 0..90 or 270..355
//   index     out  5   table index k (0..18), angle magnitude = 5k
//
// Parameter:
//   ROUND_NEAREST  1 = nearest entry, ties go to the lower angle
//                  0 = floor, the largest entry <= value
// ---------------------------------------------------------------------------
module asin_lookup #(
    parameter bit ROUND_NEAREST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [12:0] value,
    input  logic        negative,
    output logic        busy,
    output logic        done,
    output logic [8:0]  angle,
    output logic [4:0]  index
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEARCH = 2'd1;
    localparam logic [1:0] ROUND  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [12:0] FULL_SCALE = 13'd4096;
    localparam logic [4:0]  LAST_IDX   = 5'd18;

    logic [1:0]  state;
    logic [12:0] v_lat;
    logic        neg_lat;
    logic [4:0]  lo;
    logic [4:0]  hi;
    logic [2:0]  iter;

    logic [4:0]  mid;
    logic [13:0] d0;
    logic [13:0] d1;
    logic [4:0]  k_sel;
    logic [8:0]  mag;

    // sin(5k deg) in Q12. Indices beyond 18 never occur; full scale is
    // returned for them so the table stays monotonic.
    function automatic logic [12:0] sine_entry(input logic [4:0] k);
        case (k)
            5'd0:    sine_entry = 13'd0;
            5'd1:    sine_entry = 13'd357;
            5'd2:    sine_entry = 13'd711;
            5'd3:    sine_entry = 13'd1060;
            5'd4:    sine_entry = 13'd1401;
            5'd5:    sine_entry = 13'd1731;
            5'd6:    sine_entry = 13'd2048;
            5'd7:    sine_entry = 13'd2349;
            5'd8:    sine_entry = 13'd2633;
            5'd9:    sine_entry = 13'd2896;
            5'd10:   sine_entry = 13'd3138;
            5'd11:   sine_entry = 13'd3355;
            5'd12:   sine_entry = 13'd3547;
            5'd13:   sine_entry = 13'd3712;
            5'd14:   sine_entry = 13'd3849;
            5'd15:   sine_entry = 13'd3956;
            5'd16:   sine_entry = 13'd4034;
            5'd17:   sine_entry = 13'd4080;
            default: sine_entry = 13'd4096;
        endcase
    endfunction

    // Upper-biased midpoint so that lo always advances when the probe
    // succeeds; once lo == hi the probe lands on lo and nothing moves.
    always_comb begin
        mid = 5'(({1'b0, lo} + {1'b0, hi} + 6'd1) >> 1);
    end

    // Rounding step. While rounding, table[lo] <= v < table[lo+1] holds,
    // so neither distance can go negative.
    always_comb begin
        d0    = {1'b0, v_lat} - {1'b0, sine_entry(lo)};
        d1    = {1'b0, sine_entry(lo + 5'd1)} - {1'b0, v_lat};
        k_sel = lo;
        if (ROUND_NEAREST && (lo < LAST_IDX) && (d1 < d0)) begin
            k_sel = lo + 5'd1;
        end
        mag = ({4'b0, k_sel} << 2) + {4'b0, k_sel};
    end

    // Main sequencer: accept, five search iterations, one rounding cycle,
    // then a registered done pulse that coincides with busy dropping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            angle   <= 9'd0;
            index   <= 5'd0;
            v_lat   <= 13'd0;
            neg_lat <= 1'b0;
            lo      <= 5'd0;
            hi      <= 5'd0;
            iter    <= 3'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        v_lat   <= (value > FULL_SCALE) ? FULL_SCALE : value;
                        neg_lat <= negative;
                        lo      <= 5'd0;
                        hi      <= LAST_IDX;
                        iter    <= 3'd0;
                        busy    <= 1'b1;
                        state   <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (sine_entry(mid) <= v_lat) begin
                        lo <= mid;
                    end else begin
                        hi <= mid - 5'd1;
                    end
                    iter <= iter + 3'd1;
                    if (iter == 3'd4) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    index <= k_sel;
                    // Negative sines map into the fourth quadrant; a
                    // negative zero stays at 0 rather than becoming 360.
                    if (neg_lat && (k_sel != 5'd0)) begin
                        angle <= 9'd360 - mag;
                    end else begin
                        angle <= mag;
                    end
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_asin_lookup.sv
// ---------------------------------------------------------------------------
// tb_asin_lookup
//
// Self-checking bench for asin_lookup. Two instances share the stimulus:
// one rounds to nearest, the other floors. Expected results come from a
// linear-scan reference model and are queued when a request is issued;
// a negedge monitor pops and compares them whenever done pulses.
// ---------------------------------------------------------------------------
module tb_asin_lookup;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [12:0] value;
    logic        negative;

    logic        busy;
    logic        done;
    logic [8:0]  angle;
    logic [4:0]  index;

    logic        busy_f;
    logic        done_f;
    logic [8:0]  angle_f;
    logic [4:0]  index_f;

    typedef struct {
        int value;
        int angle;
        int index;
    } expect_t;

    expect_t exp_near[$];
    expect_t exp_floor[$];

    int check_count = 0;
    int fail_count  = 0;

    int sine_tbl [19] = '{0, 357, 711, 1060, 1401, 1731, 2048, 2349, 2633,
                          2896, 3138, 3355, 3547, 3712, 3849, 3956, 4034,
                          4080, 4096};

    asin_lookup #(.ROUND_NEAREST(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .value    (value),
        .negative (negative),
        .busy     (busy),
        .done     (done),
        .angle    (angle),
        .index    (index)
    );

    asin_lookup #(.ROUND_NEAREST(1'b0)) dut_floor (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .value    (value),
        .negative (negative),
        .busy     (busy_f),
        .done     (done_f),
        .angle    (angle_f),
        .index    (index_f)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts, and reports any mismatch
    task automatic checkOutput(input string tag, input int observed, input int expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference: linear scan for the floor entry, then optional rounding
    function automatic expect_t model(input int v, input bit neg, input bit nearest);
        expect_t e;
        int sv;
        int k;
        sv = (v > 4096) ? 4096 : v;
        k  = 0;
        for (int i = 0; i < 19; i++) begin
            if (sine_tbl[i] <= sv) k = i;
        end
        if (nearest && k < 18 && (sine_tbl[k+1] - sv) < (sv - sine_tbl[k])) k = k + 1;
        e.value = v;
        e.index = k;
        e.angle = (neg && k > 0) ? 360 - 5 * k : 5 * k;
        return e;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest request
    always @(negedge clk) begin
        expect_t e;
        if (done) begin
            if (exp_near.size() == 0) begin
                checkOutput("spurious_done", 1, 0);
            end else begin
                e = exp_near.pop_front();
                checkOutput($sformatf("angle v=%0d", e.value), int'(angle), e.angle);
                checkOutput($sformatf("index v=%0d", e.value), int'(index), e.index);
            end
        end
        if (done_f) begin
            if (exp_floor.size() == 0) begin
                checkOutput("spurious_done_floor", 1, 0);
            end else begin
                e = exp_floor.pop_front();
                checkOutput($sformatf("floor_angle v=%0d", e.value), int'(angle_f), e.angle);
                checkOutput($sformatf("floor_index v=%0d", e.value), int'(index_f), e.index);
            end
        end
    end

    // Issue one request (called just after a rising edge), then wait a
    // bounded number of cycles for done and check latency/busy. With
    // interfere set, a second start with another value is pulsed three
    // cycles into the search and must be ignored.
    task automatic applyStimulus(input int v, input bit neg, input bit interfere);
        int  cycles;
        bit  got;
        exp_near.push_back(model(v, neg, 1'b1));
        exp_floor.push_back(model(v, neg, 1'b0));
        value    = 13'(v);
        negative = neg;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        value    = 13'($urandom_range(0, 8191));
        negative = ~neg;
        cycles   = 0;
        got      = 1'b0;
        while (!got && cycles < 20) begin
            @(posedge clk);
            cycles++;
            if (interfere && cycles == 3) begin
                start = 1'b1;
                value = 13'd100;
            end else begin
                start = 1'b0;
            end
            #1;
            if (cycles == 1) checkOutput("busy_after_accept", int'(busy), 1);
            if (done) got = 1'b1;
        end
        checkOutput($sformatf("done_latency v=%0d", v), cycles, 7);
        checkOutput("busy_at_done", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        value    = 13'd0;
        negative = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("reset_busy",  int'(busy),  0);
        checkOutput("reset_done",  int'(done),  0);
        checkOutput("reset_angle", int'(angle), 0);
        checkOutput("reset_index", int'(index), 0);
        checkOutput("reset_floor_angle", int'(angle_f), 0);

        // Idle with no start: the monitor flags any done pulse
        repeat (10) @(posedge clk);
        #1;
        checkOutput("idle_busy", int'(busy), 0);

        // Exact hits, rounding, saturation and zero
        applyStimulus(2048, 1'b0, 1'b0);
        applyStimulus(2048, 1'b1, 1'b0);
        applyStimulus(2200, 1'b0, 1'b0);
        applyStimulus(4088, 1'b0, 1'b0);
        applyStimulus(5000, 1'b1, 1'b0);
        applyStimulus(0,    1'b1, 1'b0);
        applyStimulus(4096, 1'b0, 1'b0);
        applyStimulus(357,  1'b1, 1'b0);
        applyStimulus(8191, 1'b0, 1'b0);

        // Start during a search is ignored; next start is back-to-back
        applyStimulus(1401, 1'b0, 1'b1);
        applyStimulus(3138, 1'b1, 1'b0);
        applyStimulus(1900, 1'b1, 1'b0);

        // Random values across and beyond full scale
        for (int i = 0; i < 8; i++) begin
            applyStimulus(int'($urandom_range(0, 5000)), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Known nonzero result, then reset in the middle of a search
        applyStimulus(3956, 1'b0, 1'b0);
        value    = 13'd3000;
        negative = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("midreset_busy",  int'(busy),  0);
        checkOutput("midreset_done",  int'(done),  0);
        checkOutput("midreset_angle", int'(angle), 0);
        checkOutput("midreset_index", int'(index), 0);
        repeat (12) @(posedge clk);
        #1;
        applyStimulus(2633, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("queue_empty", exp_near.size() + exp_floor.size(), 0);

        $display("%0d/%0d checks passed", check_count - fail_count, check_count);
        $finish;
    end

endmodule
